transfer_scheduler: RTL and testbench

Sequences outbound serial transfers for the memory controller.
- Buffers parallel words arriving on each SampleData strobe in a small FIFO.
- On the controller's TransferData request, drains the FIFO onto a 1- or 2-lane serial output, selected by the controller's Mode.
- Returns a single-cycle TransferDone pulse to the controller when the drain completes.
- Sits between the memory read path/controller and the serial output pins.

---
 rtl/transfer_scheduler.sv | 96 +++++++++
 tb/tb_transfer_scheduler.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/transfer_scheduler.sv
// transfer_scheduler: FIFO-buffered words drained onto a 1- or 2-lane serial output on request.
module transfer_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          Active,
    input  logic                          Mode,
    input  logic                          SampleData,
    input  logic [DATA_WIDTH-1:0]         DataIn,
    input  logic                          TransferData,
    output logic [1:0]                    DataOut,
    output logic                          DataOutValid,
    output logic                          TransferDone,
    output logic                          Busy,
    output logic                          Empty,
    output logic                          Full,
    output logic [$clog2(FIFO_DEPTH):0]   Count,
    output logic                          Overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         rdPtr, wrPtr;
    logic [DATA_WIDTH-1:0] shiftReg;
    logic [BW-1:0]         bitCnt;
    logic                  modeQ;
    logic                  push, pop;

    // Full is judged on the current count, so a push racing a pop while full is still dropped
    assign push = SampleData && !Full;
    assign pop  = state == LOAD && Active;

    always_ff @(posedge Clk)
        if (push && !Reset) mem[wrPtr] <= DataIn;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            Count    <= '0;
            Overflow <= 1'b0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop) rdPtr <= rdPtr + 1'b1;
            Count <= Count + CW'(push) - CW'(pop);
            if (SampleData && Full) Overflow <= 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            modeQ    <= 1'b0;
            shiftReg <= '0;
            bitCnt   <= '0;
        end else if (!Active && (state == LOAD || state == SHIFT)) begin
            state    <= IDLE;
            shiftReg <= '0;
            bitCnt   <= '0;
        end else begin
            case (state)
                IDLE:
                    if (TransferData && Active) begin
                        modeQ <= Mode;
                        state <= Empty ? DONE : LOAD;
                    end
                LOAD: begin
                    shiftReg <= mem[rdPtr];
                    bitCnt   <= modeQ ? BW'(DATA_WIDTH / 2) : BW'(DATA_WIDTH);
                    state    <= SHIFT;
                end
                SHIFT: begin
                    shiftReg <= modeQ ? shiftReg << 2 : shiftReg << 1;
                    bitCnt   <= bitCnt - 1'b1;
                    if (bitCnt == BW'(1)) state <= Empty ? DONE : LOAD;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Busy         = state != IDLE;
    assign Empty        = Count == '0;
    assign Full         = Count == CW'(FIFO_DEPTH);
    assign DataOutValid = state == SHIFT;
    assign TransferDone = state == DONE;
    assign DataOut      = state != SHIFT ? 2'b00 :
                          modeQ ? shiftReg[DATA_WIDTH-1 -: 2] : {1'b0, shiftReg[DATA_WIDTH-1]};
endmodule

// File: tb/tb_transfer_scheduler.sv
// tb_transfer_scheduler: directed vectors against hand-computed serial streams for transfer_scheduler.
module tb_transfer_scheduler;
    logic       Clk = 1'b0;
    logic       Reset, Active, Mode, SampleData, TransferData;
    logic [7:0] DataIn;
    logic [1:0] DataOut;
    logic       DataOutValid, TransferDone, Busy, Empty, Full, Overflow;
    logic [2:0] Count;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] bits;
    int nValid, nDone, firstValid, lastValid, doneCyc, busyCnt, laneErr, zeroErr;

    transfer_scheduler #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
        .Clk(Clk), .Reset(Reset), .Active(Active), .Mode(Mode),
        .SampleData(SampleData), .DataIn(DataIn), .TransferData(TransferData),
        .DataOut(DataOut), .DataOutValid(DataOutValid), .TransferDone(TransferDone),
        .Busy(Busy), .Empty(Empty), .Full(Full), .Count(Count), .Overflow(Overflow)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pushWord(input logic [7:0] w);
        SampleData = 1'b1;
        DataIn     = w;
        tick();
        SampleData = 1'b0;
    endtask

    // Cycle 0 is the cycle right after the edge that samples TransferData.
    // Mode is flipped after the start to show it is only captured at the start.
    task automatic runXfer(input logic m);
        bits = '0; nValid = 0; nDone = 0; firstValid = -1; lastValid = -1;
        doneCyc = -1; busyCnt = 0; laneErr = 0; zeroErr = 0;
        Mode = m;
        TransferData = 1'b1;
        tick();
        TransferData = 1'b0;
        Mode = !m;
        for (int c = 0; c < 60; c++) begin
            if (DataOutValid) begin
                if (firstValid < 0) firstValid = c;
                lastValid = c;
                nValid++;
                bits = m ? {bits[61:0], DataOut} : {bits[62:0], DataOut[0]};
                if (!m && DataOut[1]) laneErr++;
            end else if (DataOut != 2'b00) zeroErr++;
            if (TransferDone) begin
                nDone++;
                doneCyc = c;
            end
            if (Busy) busyCnt++;
            tick();
        end
    endtask

    initial begin
        Reset = 1'b1; Active = 1'b0; Mode = 1'b0; SampleData = 1'b0;
        TransferData = 1'b0; DataIn = '0;
        tick(); tick();
        Reset = 1'b0;
        check("rst_busy", Busy, 0);
        check("rst_empty", Empty, 1);
        check("rst_count", Count, 0);
        check("rst_valid", DataOutValid, 0);
        check("rst_dout", DataOut, 0);
        check("rst_done", TransferDone, 0);
        check("rst_full", Full, 0);
        check("rst_ovf", Overflow, 0);

        // single word, one lane
        Active = 1'b1;
        pushWord(8'hA5);
        check("t1_count", Count, 1);
        runXfer(1'b0);
        check("t1_bits", bits[31:0], 32'h000000A5);
        check("t1_nvalid", nValid, 8);
        check("t1_first", firstValid, 1);
        check("t1_last", lastValid, 8);
        check("t1_donecyc", doneCyc, 9);
        check("t1_ndone", nDone, 1);
        check("t1_busy", busyCnt, 10);
        check("t1_lane1", laneErr, 0);
        check("t1_zero", zeroErr, 0);
        check("t1_count_end", Count, 0);

        // two words, two lanes, LOAD gap between them
        pushWord(8'hC3);
        pushWord(8'h3C);
        runXfer(1'b1);
        check("t2_bits", bits[31:0], 32'h0000C33C);
        check("t2_nvalid", nValid, 8);
        check("t2_first", firstValid, 1);
        check("t2_last", lastValid, 9);
        check("t2_donecyc", doneCyc, 10);
        check("t2_ndone", nDone, 1);
        check("t2_zero", zeroErr, 0);

        // overflow: fifth word dropped
        pushWord(8'h11);
        pushWord(8'h22);
        pushWord(8'h33);
        pushWord(8'h44);
        check("t3_ovf_before", Overflow, 0);
        pushWord(8'h55);
        check("t3_full", Full, 1);
        check("t3_count", Count, 4);
        check("t3_ovf", Overflow, 1);
        runXfer(1'b0);
        check("t3_bits", bits[31:0], 32'h11223344);
        check("t3_nvalid", nValid, 32);
        check("t3_donecyc", doneCyc, 36);
        check("t3_ndone", nDone, 1);
        check("t3_ovf_sticky", Overflow, 1);
        check("t3_empty", Empty, 1);

        // abort by dropping Active after 3 valid bits
        pushWord(8'hFF);
        pushWord(8'h5A);
        Mode = 1'b0;
        TransferData = 1'b1;
        tick();
        TransferData = 1'b0;
        tick(); tick(); tick();
        check("t4_valid3", DataOutValid, 1);
        check("t4_dout3", DataOut, 2'b01);
        Active = 1'b0;
        tick();
        check("t4_valid_off", DataOutValid, 0);
        check("t4_dout_off", DataOut, 0);
        check("t4_busy_off", Busy, 0);
        check("t4_count", Count, 1);
        nDone = 0;
        for (int c = 0; c < 6; c++) begin
            if (TransferDone) nDone++;
            tick();
        end
        check("t4_no_done", nDone, 0);
        Active = 1'b1;
        runXfer(1'b0);
        check("t4_rest_bits", bits[31:0], 32'h0000005A);
        check("t4_rest_ndone", nDone, 1);

        // empty transfer: acknowledged with no data
        runXfer(1'b0);
        check("t5_ndone", nDone, 1);
        check("t5_donecyc", doneCyc, 0);
        check("t5_nvalid", nValid, 0);
        // inactive request: no response
        Active = 1'b0;
        runXfer(1'b0);
        check("t5_inactive_done", nDone, 0);
        check("t5_inactive_busy", busyCnt, 0);
        Active = 1'b1;

        // reset mid-transfer with a word pushed during SHIFT
        pushWord(8'hAA);
        Mode = 1'b0;
        TransferData = 1'b1;
        tick();
        TransferData = 1'b0;
        tick(); tick();
        pushWord(8'h81);
        check("t6_count_pre", Count, 1);
        check("t6_valid_pre", DataOutValid, 1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("t6_valid", DataOutValid, 0);
        check("t6_dout", DataOut, 0);
        check("t6_done", TransferDone, 0);
        check("t6_busy", Busy, 0);
        check("t6_count", Count, 0);
        check("t6_empty", Empty, 1);
        check("t6_full", Full, 0);
        check("t6_ovf", Overflow, 0);
        pushWord(8'h81);
        runXfer(1'b0);
        check("t6_bits", bits[31:0], 32'h00000081);
        check("t6_ndone", nDone, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
